// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the 8-bit stack-machine CPU control path.
//   state_t   : controller FSM states (4-bit encoding, 10 states used)
//   OPC_*     : 3-bit opcodes carried in IR[7:5]
//   ALU_*     : 2-bit ALU function codes driven on ALUOP
package stack_cpu_pkg;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_POP_A  = 4'd2,
        ST_POP_B  = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WB     = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_PUSH_M = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_JZ     = 4'd9
    } state_t;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_AND  = 3'b010;
    localparam logic [2:0] OPC_NOT  = 3'b011;
    localparam logic [2:0] OPC_PUSH = 3'b100;
    localparam logic [2:0] OPC_POP  = 3'b101;
    localparam logic [2:0] OPC_JMP  = 3'b110;
    localparam logic [2:0] OPC_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore control unit for the 8-bit stack-machine CPU.
// Sequences one instruction at a time and drives every datapath strobe.
//
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   opc[2:0]        : opcode from IR[7:5], consulted only in ID, POP_A, EXEC
//   ALUOP[1:0]      : ALU function (00 add, 01 sub, 10 and, 11 not A)
//   pcWriteUnCond   : unconditional PC load
//   pcWriteCond     : PC load qualified by datapath zero flag
//   IorD            : memory address select (0 PC, 1 IR[4:0])
//   memRead/memWrite: memory strobes (write data = A)
//   IRWrite         : IR load
//   MtoS            : stack input select (0 ALU reg, 1 MDR)
//   push/pop/tos    : stack controls
//   ldA/ldB         : A/B register loads from stack output
//   srcA/srcB       : ALU operand selects (PC / constant 1 when set)
//   pcSrc           : PC source (0 ALU out, 1 IR[4:0])
//   instrDone       : one-cycle pulse in the last state of each instruction
module stack_cpu_controller
    import stack_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opc,
    output logic [1:0] ALUOP,
    output logic       pcWriteUnCond,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       pcSrc,
    output logic       instrDone
);

    state_t state_reg;
    state_t state_next;

    // Set by reset and cleared one cycle after rst is sampled low. It keeps the
    // FSM parked in IF with all strobes quiet for that cycle, so the first
    // fetch strobes appear in the cycle after rst is seen low.
    logic hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IF;
            hold_reg  <= 1'b1;
        end else begin
            hold_reg <= 1'b0;
            if (!hold_reg) begin
                state_reg <= state_next;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_next = ST_IF;
        case (state_reg)
            ST_IF:     state_next = ST_ID;
            ST_ID: begin
                case (opc)
                    OPC_JMP:  state_next = ST_IF;
                    OPC_JZ:   state_next = ST_JZ;
                    OPC_PUSH: state_next = ST_MEM_RD;
                    default:  state_next = ST_POP_A;
                endcase
            end
            ST_POP_A: begin
                case (opc)
                    OPC_POP: state_next = ST_MEM_WR;
                    OPC_NOT: state_next = ST_EXEC;
                    default: state_next = ST_POP_B;
                endcase
            end
            ST_POP_B:  state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     state_next = ST_IF;
            ST_MEM_RD: state_next = ST_PUSH_M;
            ST_PUSH_M: state_next = ST_IF;
            ST_MEM_WR: state_next = ST_IF;
            ST_JZ:     state_next = ST_IF;
            default:   state_next = ST_IF;
        endcase
    end

    // Output decode. rst gates the strobes combinationally so that no PC, IR
    // or stack write can occur at the edge where reset is sampled.
    always_comb begin
        ALUOP         = ALU_ADD;
        pcWriteUnCond = 1'b0;
        pcWriteCond   = 1'b0;
        IorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        IRWrite       = 1'b0;
        MtoS          = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        tos           = 1'b0;
        ldA           = 1'b0;
        ldB           = 1'b0;
        srcA          = 1'b0;
        srcB          = 1'b0;
        pcSrc         = 1'b0;
        instrDone     = 1'b0;
        if (!(rst || hold_reg)) begin
            case (state_reg)
                ST_IF: begin
                    memRead       = 1'b1;
                    IRWrite       = 1'b1;
                    srcA          = 1'b1;   // PC + 1
                    srcB          = 1'b1;
                    pcWriteUnCond = 1'b1;
                end
                ST_ID: begin
                    tos = 1'b1;             // zero flag for JZ comes from top of stack
                    if (opc == OPC_JMP) begin
                        pcSrc         = 1'b1;
                        pcWriteUnCond = 1'b1;
                        instrDone     = 1'b1;
                    end
                end
                ST_POP_A: begin
                    pop = 1'b1;
                    ldA = 1'b1;
                end
                ST_POP_B: begin
                    pop = 1'b1;
                    ldB = 1'b1;
                end
                ST_EXEC: begin
                    ALUOP = opc[1:0];       // ALU opcodes map directly onto ALUOP
                end
                ST_WB: begin
                    push      = 1'b1;
                    instrDone = 1'b1;
                end
                ST_MEM_RD: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                end
                ST_PUSH_M: begin
                    MtoS      = 1'b1;
                    push      = 1'b1;
                    instrDone = 1'b1;
                end
                ST_MEM_WR: begin
                    IorD      = 1'b1;
                    memWrite  = 1'b1;
                    instrDone = 1'b1;
                end
                ST_JZ: begin
                    pcSrc       = 1'b1;
                    pcWriteCond = 1'b1;
                    instrDone   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench for stack_cpu_controller: an instruction-level model produces the
// expected strobe vector for every cycle; one compare process checks it on
// each falling edge, together with the mutual-exclusion rules.
module tb_stack_cpu_controller;
    import stack_cpu_pkg::*;

    typedef struct packed {
        logic [1:0] alu;
        logic pwu, pwc, iord, mr, mw, irw, mtos, push, pop, tos, lda, ldb, srca, srcb, pcsrc, done;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opc = 3'b000;
    logic [1:0] ALUOP;
    logic pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS;
    logic push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, instrDone;

    stack_cpu_controller dut (
        .clk(clk), .rst(rst), .opc(opc), .ALUOP(ALUOP),
        .pcWriteUnCond(pcWriteUnCond), .pcWriteCond(pcWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
        .push(push), .pop(pop), .tos(tos), .ldA(ldA), .ldB(ldB),
        .srcA(srcA), .srcB(srcB), .pcSrc(pcSrc), .instrDone(instrDone)
    );

    always #5 clk = ~clk;

    ctl_t dut_c;
    assign dut_c = {ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite,
                    MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, instrDone};

    int   errors = 0;
    int   checks = 0;
    ctl_t exp_c = '0;
    logic exp_valid = 1'b0;
    int   cyc = 0;
    int   last_if = 0;
    int   meas_lat = 0;

    // Instruction length in cycles, from the instruction's micro-steps.
    function automatic int lat(input logic [2:0] op);
        case (op)
            OPC_JMP:           return 2;
            OPC_JZ:            return 3;
            OPC_PUSH, OPC_POP: return 4;
            OPC_NOT:           return 5;
            default:           return 6;
        endcase
    endfunction

    // Expected strobes for micro-step 'step' of instruction 'op'.
    function automatic ctl_t model(input logic [2:0] op, input int step);
        ctl_t c;
        int   nops;
        c = '0;
        nops = (op == OPC_NOT) ? 1 : 2;
        if (step == 0) begin
            c.mr = 1; c.irw = 1; c.srca = 1; c.srcb = 1; c.pwu = 1;
        end else if (step == 1) begin
            c.tos = 1;
            if (op == OPC_JMP) begin c.pcsrc = 1; c.pwu = 1; c.done = 1; end
        end else begin
            case (op)
                OPC_PUSH: begin
                    if (step == 2) begin c.iord = 1; c.mr = 1; end
                    else begin c.mtos = 1; c.push = 1; c.done = 1; end
                end
                OPC_POP: begin
                    if (step == 2) begin c.pop = 1; c.lda = 1; end
                    else begin c.iord = 1; c.mw = 1; c.done = 1; end
                end
                OPC_JZ: begin c.pcsrc = 1; c.pwc = 1; c.done = 1; end
                default: begin
                    if (step < 2 + nops) begin
                        c.pop = 1;
                        if (step == 2) c.lda = 1; else c.ldb = 1;
                    end else if (step == 2 + nops) begin
                        c.alu = op[1:0];
                    end else begin
                        c.push = 1; c.done = 1;
                    end
                end
            endcase
        end
        return c;
    endfunction

    // Single compare process: model vs DUT, plus exclusivity rules.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (exp_valid) begin
            checks = checks + 1;
            if (dut_c !== exp_c) begin
                errors = errors + 1;
                $display("FAIL ctl cyc=%0d got=%h want=%h", cyc, dut_c, exp_c);
            end
            checks = checks + 1;
            if ((push && pop) || (pcWriteUnCond && pcWriteCond) || (memRead && memWrite)) begin
                errors = errors + 1;
                $display("FAIL excl cyc=%0d got push/pop=%b%b pcw=%b%b mem=%b%b want no pair",
                         cyc, push, pop, pcWriteUnCond, pcWriteCond, memRead, memWrite);
            end
        end
        if (memRead && IRWrite) begin
            meas_lat = cyc - last_if;
            last_if  = cyc;
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Run steps [0, nsteps) of instruction op. opc carries junk in steps where
    // the controller must ignore it.
    task automatic run_steps(input logic [2:0] op, input int nsteps, input int want_lat, input bit chk_if);
        int n;
        n = lat(op);
        for (int s = 0; s < nsteps; s++) begin
            @(posedge clk); #1;
            if (s == 0 || (s == n - 1 && op != OPC_JMP))
                opc = 3'($urandom_range(0, 7));
            else
                opc = op;
            exp_c = model(op, s);
            exp_valid = 1'b1;
            if (s == 0 && (want_lat != 0 || chk_if)) begin
                @(negedge clk); #1;
                if (want_lat != 0) check_lit("latency", meas_lat, want_lat);
                if (chk_if) check_lit("if_vec", int'(dut_c), 32'h0940C);
            end
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input int want_lat, input bit chk_if);
        run_steps(op, lat(op), want_lat, chk_if);
    endtask

    // rst high for n cycles, then one quiet cycle after release.
    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; exp_c = '0; exp_valid = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; exp_c = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(2);
        check_lit("reset_zero", int'(dut_c), 0);
        // Directed sequence; each call checks the previous instruction's length.
        run_instr(OPC_ADD,  0, 1'b1);
        run_instr(OPC_SUB,  6, 1'b0);
        run_instr(OPC_AND,  6, 1'b0);
        run_instr(OPC_NOT,  6, 1'b0);
        run_instr(OPC_PUSH, 5, 1'b0);
        run_instr(OPC_POP,  4, 1'b0);
        run_instr(OPC_JMP,  4, 1'b0);
        run_instr(OPC_JZ,   2, 1'b0);
        run_instr(OPC_ADD,  3, 1'b0);
        // Reset in POP_B of a SUB: that cycle and the next are quiet, then IF.
        run_steps(OPC_SUB, 3, 0, 1'b0);
        apply_reset(1);
        run_instr(OPC_NOT, 0, 1'b1);
        // Reset in MEM_RD of a PUSH, then again mid-POP.
        run_steps(OPC_PUSH, 2, 5, 1'b0);
        apply_reset(1);
        run_instr(OPC_JZ, 0, 1'b1);
        run_steps(OPC_POP, 3, 3, 1'b0);
        apply_reset(2);
        run_instr(OPC_JMP, 0, 1'b1);
        // Random opcode stream.
        for (int i = 0; i < 1000; i++) begin
            run_instr(3'($urandom_range(0, 7)), 0, 1'b0);
        end
        @(posedge clk); #1;
        exp_valid = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
